// File: rtl/execute_stage.sv
// Execute stage of the Processor-Z Y86-style datapath: ALU, condition codes,
// cnd evaluation and an iterative shift-add multiplier behind a valid/ready output slot.
module execute_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [31:0] valA,
  input  logic [31:0] valB,
  input  logic [31:0] valC,
  input  logic [3:0]  dstE_in,
  input  logic [3:0]  dstM_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] valE,
  output logic [31:0] valA_out,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic        cnd,
  output logic [2:0]  cc
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 4;
  localparam int unsigned CW   = 5;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [RW-1:0] REG_NONE = 4'hF;
  localparam logic [CW-1:0] MUL_LAST = 5'd31;

  localparam logic [3:0] I_RRMOVL = 4'h2;
  localparam logic [3:0] I_IRMOVL = 4'h3;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;

  localparam logic [3:0] F_SUB = 4'h1;
  localparam logic [3:0] F_AND = 4'h2;
  localparam logic [3:0] F_XOR = 4'h3;
  localparam logic [3:0] F_MUL = 4'h4;

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [RW-1:0]   r_p_dste;
  logic [RW-1:0]   r_p_dstm;
  logic [XLEN-1:0] r_p_vala;

  logic            r_zf;
  logic            r_sf;
  logic            r_of;

  logic            r_out_valid;
  logic [XLEN-1:0] r_vale;
  logic [XLEN-1:0] r_vala_out;
  logic [RW-1:0]   r_dste;
  logic [RW-1:0]   r_dstm;
  logic            r_cnd;

  logic            w_slot_free;
  logic            w_accept;
  logic            w_is_mul;
  logic            w_mul_last;
  logic            w_mul_done;
  logic [XLEN-1:0] w_mul_step;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_alu_val;
  logic            w_alu_of;
  logic            w_lt;
  logic            w_cond;
  logic            w_cnd;
  logic [RW-1:0]   w_dste;

  // Handshake: the output slot frees when empty or being consumed this cycle.
  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = (r_state == S_IDLE) && w_slot_free;
  assign w_accept    = in_valid && in_ready;
  assign w_is_mul    = (icode == I_OPL) && (ifun == F_MUL);
  assign w_mul_last  = (r_cnt == MUL_LAST);
  assign w_mul_done  = (r_state == S_MUL) && w_mul_last && w_slot_free;
  assign w_mul_step  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  assign out_valid = r_out_valid;
  assign valE      = r_vale;
  assign valA_out  = r_vala_out;
  assign dstE      = r_dste;
  assign dstM      = r_dstm;
  assign cnd       = r_cnd;
  assign cc        = {r_zf, r_sf, r_of};

  // Single-cycle ALU result and overflow
  always_comb begin
    w_sum     = valB + valA;
    w_diff    = valB - valA;
    w_alu_val = '0;
    w_alu_of  = 1'b0;
    case (icode)
      I_RRMOVL:          w_alu_val = valA;
      I_IRMOVL:          w_alu_val = valC;
      I_RMMOVL, I_MRMOVL: w_alu_val = valB + valC;
      I_OPL: begin
        case (ifun)
          F_SUB: begin
            w_alu_val = w_diff;
            w_alu_of  = (valB[XLEN-1] != valA[XLEN-1]) && (w_diff[XLEN-1] != valB[XLEN-1]);
          end
          F_AND:   w_alu_val = valB & valA;
          F_XOR:   w_alu_val = valB ^ valA;
          F_MUL:   w_alu_val = '0;
          default: begin
            w_alu_val = w_sum;
            w_alu_of  = (valA[XLEN-1] == valB[XLEN-1]) && (w_sum[XLEN-1] != valB[XLEN-1]);
          end
        endcase
      end
      I_CALL, I_PUSHL: w_alu_val = valB - 32'd4;
      I_RET, I_POPL:   w_alu_val = valB + 32'd4;
      default:         w_alu_val = '0;
    endcase
  end

  // Branch/move condition, evaluated on the flags before this instruction
  always_comb begin
    w_lt   = r_sf ^ r_of;
    w_cond = 1'b0;
    case (ifun)
      4'h0:    w_cond = 1'b1;
      4'h1:    w_cond = w_lt | r_zf;
      4'h2:    w_cond = w_lt;
      4'h3:    w_cond = r_zf;
      4'h4:    w_cond = !r_zf;
      4'h5:    w_cond = !w_lt;
      4'h6:    w_cond = !w_lt && !r_zf;
      default: w_cond = 1'b0;
    endcase
    w_cnd  = ((icode == I_RRMOVL) || (icode == I_JXX)) && w_cond;
    w_dste = ((icode == I_RRMOVL) && !w_cond) ? REG_NONE : dstE_in;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
      S_MUL:   if (w_mul_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Shift-add multiplier; parks at the last count while the output slot is busy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_p_dste <= REG_NONE;
      r_p_dstm <= REG_NONE;
      r_p_vala <= '0;
    end else if (w_accept && w_is_mul) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= valB;
      r_mplier <= valA;
      r_p_dste <= dstE_in;
      r_p_dstm <= dstM_in;
      r_p_vala <= valA;
    end else if (r_state == S_MUL) begin
      if (w_mul_done) begin
        r_cnt <= '0;
      end else if (!w_mul_last) begin
        r_acc    <= w_mul_step;
        r_mcand  <= {r_mcand[XLEN-2:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
        r_cnt    <= r_cnt + CW'(1);
      end
    end
  end

  // Result slot and condition codes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_vale      <= '0;
      r_vala_out  <= '0;
      r_dste      <= REG_NONE;
      r_dstm      <= REG_NONE;
      r_cnd       <= 1'b0;
      r_zf        <= 1'b1;
      r_sf        <= 1'b0;
      r_of        <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out_valid <= 1'b1;
      r_vale      <= w_alu_val;
      r_vala_out  <= valA;
      r_dste      <= w_dste;
      r_dstm      <= dstM_in;
      r_cnd       <= w_cnd;
      if (icode == I_OPL) begin
        r_zf <= (w_alu_val == '0);
        r_sf <= w_alu_val[XLEN-1];
        r_of <= w_alu_of;
      end
    end else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_vale      <= w_mul_step;
      r_vala_out  <= r_p_vala;
      r_dste      <= r_p_dste;
      r_dstm      <= r_p_dstm;
      r_cnd       <= 1'b0;
      r_zf        <= (w_mul_step == '0);
      r_sf        <= w_mul_step[XLEN-1];
      r_of        <= 1'b0;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
